// File: rtl/convolve_fpga_div_pkg.sv
// rtl/convolve_fpga_div_pkg.sv - shared widths, state encoding and saturation constants for the convolve divider
package convolve_fpga_div_pkg;

    localparam int DIVIDEND_WIDTH = 16;
    localparam int DIVISOR_WIDTH  = 8;
    localparam int CNT_W          = $clog2(DIVIDEND_WIDTH);

    // Divide-by-zero results, chosen by the sign of the dividend
    localparam logic [DIVIDEND_WIDTH-1:0] QMAX = 16'h7FFF;
    localparam logic [DIVIDEND_WIDTH-1:0] QMIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/convolve_fpga_div_seq_core.sv
// rtl/convolve_fpga_div_seq_core.sv - iterative unsigned restoring divide datapath, one quotient bit per ce cycle
module convolve_fpga_div_seq_core
    import convolve_fpga_div_pkg::*;
#(
    parameter int DW = DIVIDEND_WIDTH,
    parameter int VW = DIVISOR_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          start,
    input  logic [DW-1:0] dividend_mag,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] q_mag,
    output logic [VW-1:0] r_mag
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    // The largest magnitude (32768 from -32768) still fits DW unsigned bits,
    // so DW iterations cover every dividend bit. dq shifts dividend bits out
    // at the top and quotient bits in at the bottom.
    logic [DW-1:0] dq;
    logic [VW-1:0] r;
    logic [VW-1:0] divisor_q;
    logic [CW-1:0] cnt;
    logic          active;

    logic [VW:0]   trial;
    logic [VW+1:0] diff;
    logic          fits;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        trial = {r, dq[DW-1]};
        diff  = {1'b0, trial} - {2'b00, divisor_q};
        fits  = ~diff[VW+1];
    end

    // Load on start, then one restoring step per ce cycle; done pulses after the last step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq        <= '0;
            r         <= '0;
            divisor_q <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            if (start) begin
                dq        <= dividend_mag;
                r         <= '0;
                divisor_q <= divisor;
                cnt       <= '0;
                active    <= 1'b1;
            end else if (active) begin
                dq  <= {dq[DW-2:0], fits};
                r   <= fits ? diff[VW-1:0] : trial[VW-1:0];
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign q_mag = dq;
    assign r_mag = r;

endmodule

// File: rtl/convolve_fpga_div_seq_16s_8ns_16.sv
// rtl/convolve_fpga_div_seq_16s_8ns_16.sv - signed/unsigned sequential divider top; CONVOLVE_FPGA_DIV_ROUND_EN selects round-half-away-from-zero
module convolve_fpga_div_seq_16s_8ns_16
    import convolve_fpga_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = convolve_fpga_div_pkg::DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = convolve_fpga_div_pkg::DIVISOR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] dout,
    output logic [DIVISOR_WIDTH:0]    rem,
    output logic                      dbz
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;

    div_state_t    state;
    div_state_t    state_nxt;

    logic          accept;
    logic          finish;
    logic          core_done;
    logic          sign_q;
    logic          dbz_q;
    logic [DW-1:0] din0_mag;
    logic [DW-1:0] q_mag;
    logic [DW-1:0] q_fin;
    logic [DW-1:0] q_signed;
    logic [VW-1:0] r_mag;
    logic [VW:0]   r_signed;

    // Magnitude of the dividend; -32768 becomes 0x8000 read as unsigned
    always_comb begin
        din0_mag = din0[DW-1] ? (~din0 + 1'b1) : din0;
    end

    assign accept = in_valid & (state == IDLE);
    assign finish = core_done & (state == BUSY);

    convolve_fpga_div_seq_core #(
        .DW(DW),
        .VW(VW)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .start       (accept),
        .dividend_mag(din0_mag),
        .divisor     (din1),
        .done        (core_done),
        .q_mag       (q_mag),
        .r_mag       (r_mag)
    );

    // State register, advances only on ce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (core_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CONVOLVE_FPGA_DIV_ROUND_EN
    logic [VW-1:0] divisor_q;

    // Divisor copy for the half-way comparison at the end of the division
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor_q <= '0;
        end else if (ce && accept) begin
            divisor_q <= din1;
        end
    end

    // Round half away from zero; divisor >= 2 whenever this adds, so no overflow
    always_comb begin
        q_fin = q_mag;
        if (!dbz_q && ({r_mag, 1'b0} >= {1'b0, divisor_q})) begin
            q_fin = q_mag + 1'b1;
        end
    end
`else
    // Truncation toward zero only
    always_comb begin
        q_fin = q_mag;
    end
`endif

    // Reapply the dividend sign to quotient and remainder
    always_comb begin
        q_signed = sign_q ? (~q_fin + 1'b1) : q_fin;
        r_signed = sign_q ? (~{1'b0, r_mag} + 1'b1) : {1'b0, r_mag};
    end

    // Capture sign/zero-divisor at accept; publish the result on entry to DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            dbz_q  <= 1'b0;
            dout   <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                sign_q <= din0[DW-1];
                dbz_q  <= (din1 == '0);
            end
            if (finish) begin
                if (dbz_q) begin
                    dout <= sign_q ? QMIN : QMAX;
                    rem  <= '0;
                    dbz  <= 1'b1;
                end else begin
                    dout <= q_signed;
                    rem  <= r_signed;
                    dbz  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_convolve_fpga_div_seq_16s_8ns_16.sv
// tb/tb_convolve_fpga_div_seq_16s_8ns_16.sv - directed self-checking bench for the convolve divider
module tb_convolve_fpga_div_seq_16s_8ns_16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        ce_tog;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din0;
    logic [7:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic [8:0]  rem;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_pos1000;
    logic [15:0] exp_neg1000;

    convolve_fpga_div_seq_16s_8ns_16 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .rem      (rem),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ce_tog) ce = ~ce;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_div(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (ce) begin
                acc = 1'b1;
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_accept"}, {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] ed, input logic [8:0] er, input logic edbz);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (ce) n++;
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, {31'd0, got}, 32'd1);
        check({tag, "_lat"}, n, 32'd17);
        check({tag, "_dout"}, {16'd0, dout}, {16'd0, ed});
        check({tag, "_rem"}, {23'd0, rem}, {23'd0, er});
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, edbz});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (ce) break;
        end
        @(negedge clk);
        check({tag, "_rel_ov"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rel_ir"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
`ifdef CONVOLVE_FPGA_DIV_ROUND_EN
        exp_pos1000 = 16'd143;
        exp_neg1000 = 16'hFF71;
`else
        exp_pos1000 = 16'd142;
        exp_neg1000 = 16'hFF72;
`endif
        reset_n   = 1'b0;
        ce        = 1'b1;
        ce_tog    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din0      = '0;
        din1      = '0;
        repeat (3) @(negedge clk);
        check("rst_ir", {31'd0, in_ready}, 32'd1);
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_rem", {23'd0, rem}, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);
        reset_n = 1'b1;

        start_div("p1000", 16'd1000, 8'd7);
        wait_result("p1000", exp_pos1000, 9'd6, 1'b0);
        release_result("p1000");

        start_div("n1000", 16'hFC18, 8'd7);
        wait_result("n1000", exp_neg1000, 9'h1FA, 1'b0);
        release_result("n1000");

        start_div("min", 16'h8000, 8'd1);
        wait_result("min", 16'h8000, 9'd0, 1'b0);
        release_result("min");

        start_div("max", 16'h7FFF, 8'd255);
        wait_result("max", 16'd128, 9'd127, 1'b0);
        release_result("max");

        start_div("dbzp", 16'd500, 8'd0);
        wait_result("dbzp", 16'h7FFF, 9'd0, 1'b1);
        release_result("dbzp");

        start_div("dbzn", 16'hFE0C, 8'd0);
        wait_result("dbzn", 16'h8000, 9'd0, 1'b1);
        release_result("dbzn");

        out_ready = 1'b0;
        start_div("bp", 16'd100, 8'd3);
        wait_result("bp", 16'd33, 9'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                din0     = 16'd7;
                din1     = 8'd1;
                in_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            check("bp_ov", {31'd0, out_valid}, 32'd1);
            check("bp_ir", {31'd0, in_ready}, 32'd0);
            check("bp_dout", {16'd0, dout}, 32'd33);
            check("bp_rem", {23'd0, rem}, 32'd1);
        end
        in_valid  = 1'b0;
        ce        = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ce_hold_ov", {31'd0, out_valid}, 32'd1);
        ce = 1'b1;
        release_result("bp");

        ce_tog = 1'b1;
        start_div("cetog", 16'd1000, 8'd7);
        wait_result("cetog", exp_pos1000, 9'd6, 1'b0);
        release_result("cetog");
        @(posedge clk);
        #1;
        ce_tog = 1'b0;
        ce     = 1'b1;

        start_div("rstmid", 16'd1000, 8'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstmid_ir", {31'd0, in_ready}, 32'd1);
        check("rstmid_ov", {31'd0, out_valid}, 32'd0);
        check("rstmid_dout", {16'd0, dout}, 32'd0);
        check("rstmid_rem", {23'd0, rem}, 32'd0);
        check("rstmid_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        start_div("d84", 16'd84, 8'd4);
        wait_result("d84", 16'd21, 9'd0, 1'b0);
        release_result("d84");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
